// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default widths, exponentiation scheduler state encoding
// and the constant used to leave the Montgomery domain.
package rsa_pkg;

   localparam int N    = 512;
   localparam int ELEN = 512;
   localparam int LW   = 10;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CONV_I = 4'd1,
      S_CONV_W = 4'd2,
      S_SQ_I   = 4'd3,
      S_SQ_W   = 4'd4,
      S_MUL_I  = 4'd5,
      S_MUL_W  = 4'd6,
      S_OUT_I  = 4'd7,
      S_OUT_W  = 4'd8,
      S_FIN    = 4'd9
   } state_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply scheduler driving a single Montgomery
// multiplier: domain entry, exponent scan, domain exit, one-cycle done.
module mont_exp_ctrl #(
   parameter int N    = rsa_pkg::N,
   parameter int ELEN = rsa_pkg::ELEN,
   parameter int LW   = rsa_pkg::LW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [N-1:0]    in_x,
   input  logic [N-1:0]    in_r,
   input  logic [N-1:0]    in_r2,
   input  logic [N-1:0]    in_m,
   input  logic [ELEN-1:0] in_e,
   input  logic [LW-1:0]   in_elen,
   output logic            busy,
   output logic            done,
   output logic [N-1:0]    result,
   output logic            mm_start,
   output logic [N-1:0]    mm_a,
   output logic [N-1:0]    mm_b,
   output logic [N-1:0]    mm_m,
   input  logic [N-1:0]    mm_result,
   input  logic            mm_done
);
   import rsa_pkg::*;

   localparam logic [N-1:0]  ONE_N  = N'(1);
   localparam logic [LW-1:0] ELEN_L = LW'(ELEN);

   state_t          state, state_n;
   logic [N-1:0]    acc, acc_n;
   logic [N-1:0]    xm, xm_n;
   logic [N-1:0]    a_n, b_n, res_n;
   logic [N-1:0]    m_q;
   logic [ELEN-1:0] e_q, e_sh;
   logic [LW-1:0]   t_q, t_in;
   logic [LW-1:0]   idx, idx_n;
   logic            take;

   assign t_in     = (in_elen > ELEN_L) ? ELEN_L : in_elen;
   assign e_sh     = e_q >> idx;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FIN);
   assign mm_start = (state == S_CONV_I) || (state == S_SQ_I) ||
                     (state == S_MUL_I)  || (state == S_OUT_I);
   assign mm_m     = m_q;

   // Operands for the next issue state are computed here so they are already
   // registered in the cycle mm_start goes high.
   always_comb begin
      state_n = state;
      acc_n   = acc;
      xm_n    = xm;
      idx_n   = idx;
      a_n     = mm_a;
      b_n     = mm_b;
      res_n   = result;
      take    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               take  = 1'b1;
               acc_n = in_r;
               if (t_in == '0) begin
                  state_n = S_OUT_I;
                  a_n     = in_r;
                  b_n     = ONE_N;
               end else begin
                  state_n = S_CONV_I;
                  a_n     = in_x;
                  b_n     = in_r2;
               end
            end
         end
         S_CONV_I: state_n = S_CONV_W;
         S_CONV_W: begin
            if (mm_done) begin
               xm_n    = mm_result;
               idx_n   = t_q - LW'(1);
               state_n = S_SQ_I;
               a_n     = acc;
               b_n     = acc;
            end
         end
         S_SQ_I: state_n = S_SQ_W;
         S_SQ_W: begin
            if (mm_done) begin
               acc_n = mm_result;
               a_n   = mm_result;
               if (e_sh[0]) begin
                  state_n = S_MUL_I;
                  b_n     = xm;
               end else if (idx == '0) begin
                  state_n = S_OUT_I;
                  b_n     = ONE_N;
               end else begin
                  idx_n   = idx - LW'(1);
                  state_n = S_SQ_I;
                  b_n     = mm_result;
               end
            end
         end
         S_MUL_I: state_n = S_MUL_W;
         S_MUL_W: begin
            if (mm_done) begin
               acc_n = mm_result;
               a_n   = mm_result;
               if (idx == '0) begin
                  state_n = S_OUT_I;
                  b_n     = ONE_N;
               end else begin
                  idx_n   = idx - LW'(1);
                  state_n = S_SQ_I;
                  b_n     = mm_result;
               end
            end
         end
         S_OUT_I: state_n = S_OUT_W;
         S_OUT_W: begin
            if (mm_done) begin
               res_n   = mm_result;
               state_n = S_FIN;
            end
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         acc    <= '0;
         xm     <= '0;
         idx    <= '0;
         mm_a   <= '0;
         mm_b   <= '0;
         result <= '0;
         m_q    <= '0;
         e_q    <= '0;
         t_q    <= '0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         xm     <= xm_n;
         idx    <= idx_n;
         mm_a   <= a_n;
         mm_b   <= b_n;
         result <= res_n;
         if (take) begin
            m_q <= in_m;
            e_q <= in_e;
            t_q <= t_in;
         end
      end
   end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery multiplier
// of configurable latency and a plain modular-power reference.
module tb_mont_exp_ctrl;
   localparam int N = 8, ELEN = 8, LW = 4;

   logic            clk = 1'b0;
   logic            reset, start;
   logic [N-1:0]    in_x, in_r, in_r2, in_m;
   logic [ELEN-1:0] in_e;
   logic [LW-1:0]   in_elen;
   logic            busy, done, mm_start, mm_done;
   logic [N-1:0]    result, mm_a, mm_b, mm_m, mm_result;

   mont_exp_ctrl #(.N(N), .ELEN(ELEN), .LW(LW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_x(in_x), .in_r(in_r), .in_r2(in_r2), .in_m(in_m),
      .in_e(in_e), .in_elen(in_elen),
      .busy(busy), .done(done), .result(result),
      .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
      .mm_result(mm_result), .mm_done(mm_done)
   );

   always #5 clk = ~clk;

   typedef struct {int res; int cyc; int k;} exp_t;
   exp_t sb[$];

   int cyc = 0, n_chk = 0, n_pass = 0, nstart = 0, lat = 5;
   bit spur = 1'b0, kick = 1'b0;

   task automatic chk(string nm, longint got, longint want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, want);
   endtask

   function automatic int modpow(int x, int e, int t, int m);
      int r, b;
      r = 1 % m;
      b = x % m;
      for (int i = 0; i < t; i++) begin
         if (e[i]) r = (r * b) % m;
         b = (b * b) % m;
      end
      return r;
   endfunction

   // a*b*R^-1 mod m with R = 2^N
   function automatic int mont(int a, int b, int m);
      int rinv;
      rinv = 0;
      for (int k = 1; k < m; k++)
         if (((256 * k) % m) == 1) rinv = k;
      return (((a * b) % m) * rinv) % m;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Multiplier model: done L cycles after the mm_start cycle; optional early
   // spurious done during the issue cycle, and an on-demand done while idle.
   initial begin
      int a, b, m;
      mm_done = 1'b0;
      mm_result = '0;
      forever begin
         @(posedge clk);
         #1;
         mm_done = 1'b0;
         if (mm_start) begin
            a = int'(mm_a);
            b = int'(mm_b);
            m = int'(mm_m);
            if (spur) begin
               mm_result = N'($urandom);
               mm_done = 1'b1;
            end
            repeat (lat) begin
               @(posedge clk);
               #1;
               mm_done = 1'b0;
            end
            mm_result = N'(mont(a, b, m));
            mm_done = 1'b1;
         end else if (kick) begin
            kick = 1'b0;
            mm_result = N'($urandom);
            mm_done = 1'b1;
         end
      end
   end

   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (mm_start) nstart++;
         if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               ex = sb.pop_front();
               chk("result", result, ex.res);
               chk("done_cycle", cyc, ex.cyc);
               chk("mm_count", nstart, ex.k);
            end
            nstart = 0;
         end
      end
   end

   task automatic run(int x, int e, int tin, int m, int l, bit sp, bit abuse);
      int t, k, pc, r, n;
      exp_t ex;
      lat  = l;
      spur = sp;
      t  = (tin > ELEN) ? ELEN : tin;
      pc = 0;
      for (int i = 0; i < t; i++) pc += e[i];
      k = (t == 0) ? 1 : t + pc + 2;
      r = 256 % m;
      in_x = N'(x); in_r = N'(r); in_r2 = N'((r * r) % m); in_m = N'(m);
      in_e = ELEN'(e); in_elen = LW'(tin);
      start = 1'b1;
      ex.res = modpow(x, e, t, m);
      ex.cyc = cyc + 1 + k * (l + 1);
      ex.k   = k;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (abuse) begin
         repeat (3) @(posedge clk);
         #1;
         in_x = N'($urandom); in_m = 8'd251; in_e = 8'hFF; in_elen = 4'd8;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         chk("busy_during_abuse", busy, 1);
         chk("mm_m_held", mm_m, m);
      end
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
         chk("busy_after_done", busy, 0);
      end
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_mm_start"}, mm_start, 0);
      chk({tag, "_mm_a"}, mm_a, 0);
      chk({tag, "_mm_b"}, mm_b, 0);
      chk({tag, "_mm_m"}, mm_m, 0);
   endtask

   initial begin
      int m;
      reset = 1'b1; start = 1'b0;
      in_x = '0; in_r = '0; in_r2 = '0; in_m = '0; in_e = '0; in_elen = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      run(2, 'b1010, 4, 13, 5, 1'b0, 1'b1);   // 2^10 mod 13 = 10, with start abuse
      run(5, 1, 1, 13, 3, 1'b0, 1'b0);
      run(7, 'hFF, 0, 13, 2, 1'b0, 1'b0);
      run(0, 3, 2, 13, 2, 1'b0, 1'b0);
      run(9, $urandom_range(0, 255), ELEN + 5, 251, 1, 1'b0, 1'b0);
      run(6, 'hF5, 3, 11, 2, 1'b0, 1'b0);
      run(2, 'b1010, 4, 13, 5, 1'b1, 1'b0);   // spurious done in issue cycles

      kick = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_spur_busy", busy, 0);

      // Reset while in SQ_W of the first square
      lat = 4; spur = 1'b0;
      in_x = 8'd2; in_r = 8'd9; in_r2 = 8'd3; in_m = 8'd13; in_e = 8'b1010; in_elen = 4'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_zero("midrun");
      nstart = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("post_reset_idle", busy, 0);
      run(2, 'b1010, 4, 13, 4, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         m = $urandom_range(1, 127) * 2 + 1;
         run($urandom_range(0, m - 1), $urandom_range(0, 255), $urandom_range(0, 13),
             m, $urandom_range(1, 4), 1'(($urandom_range(0, 1))), 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

- Scheduler that sequences one Montgomery multiplier to compute modular exponentiation `result = x^e mod m` by left-to-right square-and-multiply.
- Sits between the RSA top level and the `montgomery` multiplier instance.
- Owns the multiplier's start/operand ports: converts `x` into the Montgomery domain, runs the exponent scan, then converts back.
- Returns a plain-domain result with a one-cycle done pulse.

## Interface
- `N`, 512, operand/modulus width
- `ELEN`, 512, maximum exponent width
- `LW`, 10, width of exponent-length field (must hold `ELEN`)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state and outputs
- `start` in 1: request; sampled only in IDLE
- `in_x` in N: base, plain domain, `< in_m`
- `in_r` in N: `R mod m`, with `R = 2^N`
- `in_r2` in N: `R^2 mod m`
- `in_m` in N: odd modulus
- `in_e` in ELEN: exponent, LSB-aligned
- `in_elen` in LW: number of exponent bits to scan (t); values above `ELEN` are clamped to `ELEN`
- `busy` out 1: `state != IDLE`
- `done` out 1: one-cycle pulse; `result` is valid from this cycle on
- `result` out N: last completed exponentiation; holds until the next `done`
- `mm_start` out 1: one-cycle pulse to the multiplier
- `mm_a` out N, `mm_b` out N, `mm_m` out N: registered multiplier operands
- `mm_result` in N: multiplier output
- `mm_done` in 1: multiplier completion, sampled as a pulse

## Operation
- **IDLE**, on `start`:
  - Latch `x`, `r`, `r2`, `m`, `e`, and `t = min(in_elen, ELEN)`.
  - Set accumulator `A = r`.
  - If `t == 0`, go to OUT_I; otherwise go to CONV_I.
- **CONV_I**: issue `MM(x, r2)`, then go to CONV_W.
- **CONV_W**: on `mm_done`, set `X = mm_result`, `i = t-1`, go to SQ_I.
- **SQ_I**: issue `MM(A, A)`, then go to SQ_W.
- **SQ_W**: on `mm_done`, set `A = mm_result`. Then:
  - if `e[i]`, go to MUL_I;
  - else if `i == 0`, go to OUT_I;
  - else `i--` and go to SQ_I.
- **MUL_I**: issue `MM(A, X)`, then go to MUL_W.
- **MUL_W**: on `mm_done`, set `A = mm_result`. Then:
  - if `i == 0`, go to OUT_I;
  - else `i--` and go to SQ_I.
- **OUT_I**: issue `MM(A, 1)`, then go to OUT_W.
- **OUT_W**: on `mm_done`, load `result = mm_result`, go to FIN.
- **FIN**: `done = 1` for this cycle only, then go to IDLE.
- **Issue states**:
  - `mm_start = 1` for exactly that cycle.
  - `mm_a`/`mm_b` are loaded on entry and held constant until the matching `mm_done`.
  - `mm_m` equals the latched `m` whenever `busy` is high.
- **`mm_done` handling**:
  - Honoured only in `*_W` states.
  - Ignored in IDLE, in issue states, and in FIN.
- **`start` handling**: `start` while `busy` is ignored; the latched operands are unaffected.
- **Multiplication count**:
  - `K = t + popcount(e[t-1:0]) + 2` for `t > 0`.
  - `K = 1` for `t == 0` (result = `1 mod m`).
- **Exponent bits**: bits of `in_e` at or above `t` are ignored.

## Timing
- **Reset values**: `busy=0`, `done=0`, `result=0`, `mm_start=0`, `mm_a=mm_b=mm_m=0`; state IDLE.
- **Reset mid-operation**:
  - Abort immediately with no `done`.
  - The multiplier shares `reset`; any stale `mm_done` after release is ignored, because the block is in IDLE.
- **Start**: `start` is sampled at edge 0; the first issue state is active in cycle 1.
- **Per-operation timing**, with `L` = cycles from the `mm_start` cycle to the `mm_done` cycle (L ≥ 1):
  - Each multiplication occupies `L+1` cycles.
  - The next issue follows `mm_done` by one cycle.
- **Latency**: `done` is asserted in cycle `1 + K·(L+1)`; `busy` falls the cycle after.
- **Back-to-back runs**: a new `start` is accepted in the cycle after FIN.

## Structure
- **Shared package `rsa_pkg`**: `N`, `ELEN`, `LW`, the state encoding (4-bit, 10 states), and the constant `ONE = {{N-1{0}},1}`.
- **No sub-module**: exponent index, operand mux, and FSM stay in one module; `montgomery` is instantiated as a sibling by the RSA top level.
- **Bench**: the bench uses a behavioural multiplier model with configurable `L`.

## Test plan
- **Square-and-multiply**: N=8, m=13, r=9, r2=3, x=2, e=0b1010, t=4, L=5 → K=8, `done` at cycle 49, result=10; exactly 8 `mm_start` pulses.
- **Single-bit exponent**: x=5, e=1, t=1 → 3 multiplications (CONV, SQ, MUL) plus OUT = K=4, result=5.
- **t=0 and zero base**:
  - t=0 with e=0xFF → K=1, result=1, no CONV issued.
  - x=0, e=3, t=2 → result=0.
- **Clamping and ignored bits**: `in_elen` = ELEN+5 is treated as ELEN; e bits above t are set but must not change result (compare against t-bit golden).
- **Protocol abuse**:
  - `start` pulsed while busy → ignored; result still 10.
  - Spurious `mm_done` in IDLE or in an issue cycle → no state change.
- **Reset mid-run**: assert `reset` during SQ_W → all outputs 0 within the same cycle, no `done`; a following clean run returns the correct result.
